// File: rtl/sigmoid_pkg.sv
// Shared constants, FSM state type and y clamp helper for the sigmoid backward unit.
package sigmoid_pkg;

  localparam int QN = 6;
  localparam int QM = 11;
  localparam int W  = QN + QM + 1;

  // 1.0 in Q(QN).(QM)
  localparam logic signed [W-1:0] ONE  = W'(1 << QM);
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

  // A sigmoid output lives in [0, 1]; anything outside is pinned to the nearest end.
  function automatic logic signed [W-1:0] clamp_y(input logic signed [W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > ONE)
      return ONE;
    else
      return v;
  endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed W x W fixed-point multiply, shift back by QM and saturate to W bits.
// Define SIGMOID_BWD_ROUND_EN for round-half-up; otherwise the shift truncates toward -inf.
module fxp_mul_sat
  import sigmoid_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  localparam logic signed [2*W:0] MAXW = (2*W+1)'(MAXV);
  localparam logic signed [2*W:0] MINW = (2*W+1)'(MINV);

  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   biased;
  logic signed [2*W:0]   shifted;

  assign prod = a * b;

`ifdef SIGMOID_BWD_ROUND_EN
  localparam logic signed [2*W:0] RBIAS = (2*W+1)'(1 << (QM-1));
  assign biased = {prod[2*W-1], prod} + RBIAS;
`else
  assign biased = {prod[2*W-1], prod};
`endif

  assign shifted = biased >>> QM;

  // Saturate the rescaled product into the W-bit output range.
  always_comb begin
    p = shifted[W-1:0];
    if (shifted > MAXW)
      p = MAXV;
    else if (shifted < MINW)
      p = MINV;
  end

endmodule

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: delta = grad * y * (1 - y), using one shared multiplier over two cycles.
// Rounding of both multiply stages is selected by the SIGMOID_BWD_ROUND_EN macro (see fxp_mul_sat).
module sigmoid_backward
  import sigmoid_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] grad,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] delta
);

  state_t state_reg, state_next;

  logic signed [W-1:0] y_reg, grad_reg, s_reg, delta_reg;
  logic signed [W-1:0] op_a, op_b, mul_p;

  fxp_mul_sat u_mul (
    .a (op_a),
    .b (op_b),
    .p (mul_p)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next state, handshake outputs and multiplier operand selection.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = MUL1;
      end
      MUL1: begin
        op_a       = y_reg;
        op_b       = ONE - y_reg;
        state_next = MUL2;
      end
      MUL2: begin
        op_a       = s_reg;
        op_b       = grad_reg;
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture inputs on handshake, then the two multiplier results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_reg     <= '0;
      grad_reg  <= '0;
      s_reg     <= '0;
      delta_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          y_reg    <= clamp_y(y);
          grad_reg <= grad;
        end
        MUL1:    s_reg     <= mul_p;
        MUL2:    delta_reg <= mul_p;
        default: ;
      endcase
    end
  end

  assign delta = delta_reg;

endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed bench for sigmoid_backward with hand-computed expected deltas.
`timescale 1ns/1ps
module tb_sigmoid_backward;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] y;
  logic signed [17:0] grad;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] delta;

  int checks = 0;
  int errors = 0;

  sigmoid_backward dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .grad      (grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .delta     (delta)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Handshake at edge k, expect out_valid from edge k+2, accept at edge k+3.
  task automatic txn(input string tag, input int yv, input int gv, input int exp);
    @(negedge clock);
    y = 18'(yv); grad = 18'(gv); in_valid = 1'b1; out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 1);
    @(posedge clock); #1;
    in_valid = 1'b0; y = 18'sd0; grad = 18'sd0;
    check({tag, ".lat1"}, 32'(out_valid), 0);
    @(posedge clock); #1;
    check({tag, ".lat2"}, 32'(out_valid), 0);
    @(posedge clock); #1;
    check({tag, ".valid"}, 32'(out_valid), 1);
    check({tag, ".delta"}, 32'(delta), exp);
    @(posedge clock); #1;
    check({tag, ".done"}, 32'(out_valid), 0);
    $display("txn %s y=%0d grad=%0d delta=%0d exp=%0d", tag, yv, gv, delta, exp);
  endtask

  initial begin
    int exp_round;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; y = '0; grad = '0;
    #12;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.delta", 32'(delta), 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("rst.in_ready", 32'(in_ready), 1);

    txn("t1", 1024, 2048, 512);
    txn("t2", 1536, -4096, -768);
    txn("t3a", -5, 2048, 0);
    txn("t3b", 3000, 2048, 0);
`ifdef SIGMOID_BWD_ROUND_EN
    exp_round = 1;
`else
    exp_round = 0;
`endif
    txn("t4", 1, 2048, exp_round);

    // Backpressure: result held, input ignored while pending.
    @(negedge clock);
    y = 18'sd1024; grad = 18'sd2048; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("bp.valid", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      y = 18'(100 * i + 7); grad = 18'(-300 * i); in_valid = 1'b1;
      @(posedge clock); #1;
      check("bp.hold_delta", 32'(delta), 512);
      check("bp.hold_valid", 32'(out_valid), 1);
      check("bp.in_ready", 32'(in_ready), 0);
    end
    $display("txn bp delta=%0d held for 10 cycles", delta);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp.release_valid", 32'(out_valid), 0);
    check("bp.release_ready", 32'(in_ready), 1);

    // Reset while in MUL2 discards the pending result.
    @(negedge clock);
    y = 18'sd1536; grad = 18'sd2048; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0; #1;
    check("mrst.valid", 32'(out_valid), 0);
    check("mrst.delta", 32'(delta), 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mrst.no_result", 32'(out_valid), 0);
    $display("txn mrst out_valid=%0d delta=%0d", out_valid, delta);
    @(negedge clock); reset = 1'b1;
    txn("t6", 1536, -4096, -768);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
